adder_arbiter: RTL
==================

# adder_arbiter

Shared-adder scheduler: arbitrates up to NREQ requesters onto a single WIDTH-bit adder datapath using round-robin grants. Each accepted operation is sequenced through a three-state FSM. The result is returned with carry-out, signed overflow and the requester ID over a valid/ready response channel. The block sits in front of the adder family (ripple, CLA, carry-select) so one adder instance serves several clients.

## Interface
- WIDTH, 32, operand/result width
- NREQ, 4, number of requesters (≥2); IDW = $clog2(NREQ)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of requester that issued the operation
- rsp_sum  out  WIDTH  sum[WIDTH-1:0]
- rsp_cout  out  1  carry-out (bit WIDTH of A+B+cin)
- rsp_ovf  out  1  signed overflow

## Operation
- FSM states: IDLE, ADD, RESP. Reset state is IDLE.
- IDLE:
  - Winner = first i with req_valid[i], searched from ptr+1 upward with wrap mod NREQ.
  - req_ready[winner] = 1 combinationally. All other req_ready bits are 0.
  - On handshake (valid & ready), capture A, B, cin and id into op registers, set ptr ← winner, and go to ADD.
  - No valid requester: stay in IDLE.
- ADD:
  - Compute {cout,sum} = A + B + cin at WIDTH+1 bits, unsigned.
  - ovf = (A[MSB]==B[MSB]) & (sum[MSB]!=A[MSB]).
  - Register sum, cout, ovf and id into the rsp_* outputs, set rsp_valid ← 1, and go to RESP.
  - req_ready is all 0.
- RESP:
  - Hold all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - req_ready is all 0.
- req_ready is 0 outside IDLE. The block never accepts a new request while a response is pending.
- Requesters must hold req_valid and operands stable until accepted. A valid that drops before its grant is simply not served; there is no error.
- ptr is a round-robin pointer, reset value NREQ-1, so requester 0 has first priority after reset.
- Reset (rst_n=0, any state, asynchronous):
  - state ← IDLE, ptr ← NREQ-1.
  - rsp_valid, rsp_sum, rsp_cout, rsp_ovf and rsp_id ← 0.
  - An in-flight operation is discarded and never responded.

## Timing
- Handshake in cycle T (IDLE, captured at edge ending T).
- ADD occupies cycle T+1.
- rsp_valid is high from cycle T+2.
- The response handshake in cycle T+2 at the earliest.
- IDLE is re-entered in cycle T+3 and can accept immediately. Peak throughput is 1 op per 3 cycles with rsp_ready tied high.
- Outputs are registered, except req_ready, which is combinational from req_valid, state and ptr.
- A single requester holding valid continuously is served every 3 cycles.
- With all requesters valid, grant order is strictly rotating, so no requester waits more than NREQ operations.
- Deassertion of rst_n is sampled on the next rising clk. The first grant is possible in that cycle.

## Test plan
- Req0: A=32'h7fffffff, B=32'h1, cin=0 → rsp_sum=32'h80000000, cout=0, ovf=1, id=0, rsp_valid 2 cycles after the accept cycle.
- Req2: A=32'hffffffff, B=32'h80000000 → sum=32'h7fffffff, cout=1, ovf=1, id=2. Also A=32'h2, B=32'hfffffffb → sum=32'hfffffffd, cout=0, ovf=0.
- All four requesters valid continuously after reset, rsp_ready=1:
  - Accept order is 0,1,2,3,0 with one accept every 3 cycles.
  - req_ready is always one-hot or zero.
  - Each rsp_id matches its requester's operands (e.g. req_i A=i, B=32'h10 → sum=32'h10+i).
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0 throughout. Raising rsp_ready gives one handshake, then IDLE and a new accept the next cycle.
- Carry-in: A=32'hc, B=32'h19, cin=1 → sum=32'h26, cout=0. A=32'hfffffffb, B=32'hfffffff4, cin=0 → sum=32'hffffffef, cout=1, ovf=0.
- Reset mid-operation:
  - Assert rst_n=0 during ADD → all rsp_* outputs 0 immediately and no response for the discarded op.
  - After release with req1 and req3 valid, req1 is granted first, because ptr resets to NREQ-1.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin scheduler sharing one WIDTH-bit adder among NREQ requesters; accept -> response valid in 2 cycles.
// One operation in flight; no request is accepted while a response waits for rsp_ready.
module adder_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ-1:0]         req_cin,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic [WIDTH-1:0]        rsp_sum,
   output logic                    rsp_cout,
   output logic                    rsp_ovf
);

   typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

   state_t           state_q;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   op_id_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic             op_cin_q;

   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [WIDTH-1:0] rsp_sum_q;
   logic             rsp_cout_q;
   logic             rsp_ovf_q;

   logic             win_vld;
   logic [IDW-1:0]   win_id;
   logic [IDW-1:0]   cand;
   logic [WIDTH:0]   sum_full;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   // Search starts just past the last winner so every requester gets a turn.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(ptr_q) + k) % NREQ);
         if (!win_vld && req_valid[cand]) begin
            win_vld = 1'b1;
            win_id  = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && win_vld) begin
         req_ready[win_id] = 1'b1;
      end
   end

   assign sum_full = {1'b0, op_a_q} + {1'b0, op_b_q} + {{WIDTH{1'b0}}, op_cin_q};
   assign sum_d    = sum_full[WIDTH-1:0];
   assign cout_d   = sum_full[WIDTH];
   assign ovf_d    = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (sum_d[WIDTH-1] != op_a_q[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= IDW'(NREQ - 1);
         op_id_q     <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_cin_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  op_a_q   <= req_a[int'(win_id)*WIDTH +: WIDTH];
                  op_b_q   <= req_b[int'(win_id)*WIDTH +: WIDTH];
                  op_cin_q <= req_cin[win_id];
                  op_id_q  <= win_id;
                  ptr_q    <= win_id;
                  state_q  <= ADD;
               end
            end
            ADD: begin
               rsp_sum_q   <= sum_d;
               rsp_cout_q  <= cout_d;
               rsp_ovf_q   <= ovf_d;
               rsp_id_q    <= op_id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_ovf   = rsp_ovf_q;

endmodule
